segre_imem_responder: RTL

//  Responder end of the fetch memory interface: accepts read requests from the IF stage,

---
 rtl/segre_imem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/segre_imem_responder.sv
// Fetch-side instruction memory responder: accepts IF-stage reads, answers after a fixed
// latency with the stored word (or NOP plus error on misaligned / out-of-range fetches).
module segre_imem_responder #(
  parameter int                   ADDR_SIZE   = 32,
  parameter int                   WORD_SIZE   = 32,
  parameter int                   DEPTH_WORDS = 1024,
  parameter int                   LATENCY     = 2,
  parameter logic [WORD_SIZE-1:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_rd_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic                 instr_valid_o,
  output logic                 busy_o,
  output logic                 err_o,
  input  logic                 wr_en_i,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam int         HI_W   = ADDR_SIZE - IDX_W - 2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic f_in_range(input logic [ADDR_SIZE-1:0] addr);
    return (addr[ADDR_SIZE-1:IDX_W+2] == {HI_W{1'b0}});
  endfunction

  function automatic logic f_fetch_err(input logic [ADDR_SIZE-1:0] addr);
    return (addr[1:0] != 2'b00) || !f_in_range(addr);
  endfunction

  logic [WORD_SIZE-1:0] r_mem [DEPTH_WORDS];
  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic                 w_accept;
  logic                 w_rd_err;
  logic [WORD_SIZE-1:0] w_rd_word;
  logic [WORD_SIZE-1:0] r_pipe_word;
  logic                 r_pipe_err;
  logic [WORD_SIZE-1:0] r_instr;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_err;
  logic                 w_valid_nxt;
  logic                 w_busy_nxt;
  logic                 w_load_direct;
  logic                 w_load_pipe;

  // Lookup uses the pre-edge array contents, so a same-edge write is not seen.
  assign w_rd_err  = f_fetch_err(pc_i);
  assign w_rd_word = w_rd_err ? NOP_WORD : r_mem[pc_i[IDX_W+1:2]];

  // Instruction array; preload writes outside the array are dropped.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && f_in_range(wr_addr_i)) begin
      r_mem[wr_addr_i[IDX_W+1:2]] <= wr_data_i;
    end
  end

  // State register and latency counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Next-state logic; RESP accepts back-to-back like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (mem_rd_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode for the coming cycle; single-cycle latency bypasses the pipeline register.
  always_comb begin
    w_valid_nxt   = (w_state_nxt == S_RESP);
    w_busy_nxt    = (w_state_nxt == S_WAIT);
    w_load_direct = w_valid_nxt && w_accept;
    w_load_pipe   = w_valid_nxt && !w_accept;
  end

  // Capture of the accepted fetch result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pipe_word <= NOP_WORD;
      r_pipe_err  <= 1'b0;
    end else if (w_accept) begin
      r_pipe_word <= w_rd_word;
      r_pipe_err  <= w_rd_err;
    end else begin
      r_pipe_word <= r_pipe_word;
      r_pipe_err  <= r_pipe_err;
    end
  end

  // Registered outputs; instr/err change only on entry to RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr <= NOP_WORD;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      if (w_load_direct) begin
        r_instr <= w_rd_word;
        r_err   <= w_rd_err;
      end else if (w_load_pipe) begin
        r_instr <= r_pipe_word;
        r_err   <= r_pipe_err;
      end else begin
        r_instr <= r_instr;
        r_err   <= r_err;
      end
    end
  end

  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;
  assign busy_o        = r_busy;
  assign err_o         = r_err;

endmodule
